// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Main-memory responder on the memory side of the direct-mapped cache's
// refill path. It accepts one request at a time and never queues a second one.
//   - A single-word write (write-through) is acknowledged with one beat that
//     echoes the write data and has resp_last set.
//   - A line read (refill) returns BLOCK_WORDS beats, critical word first.
//     The word offset wraps inside the line and never crosses into the next
//     line.
// The first beat of either kind appears LATENCY cycles after the accept edge.
// The backing store holds 2**MEM_AW 32-bit words. It has no reset.
//
// Parameters
//   MEM_AW       backing-store index width (depth = 2**MEM_AW words)
//   BLOCK_WORDS  words per cache line, power of two, 2..16
//   LATENCY      accept edge to first response beat, in cycles, 1..15
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous reset, active low; aborts any operation in flight
//   req_valid   request present
//   req_ready   responder can accept (high only while idle)
//   req_write   1 = single-word write, 0 = line read
//   req_addr    word address; bits above MEM_AW-1 are ignored (aliasing)
//   req_wdata   write data, sampled on accept
//   resp_valid  response beat valid, no backpressure
//   resp_data   read data or echoed write data; 0 when resp_valid is low
//   resp_last   final beat of a response; 0 when resp_valid is low
//   busy        high whenever the responder is not idle
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int MEM_AW      = 10,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_last,
  output logic        busy
);

  localparam int         OFF       = $clog2(BLOCK_WORDS);
  localparam int         DEPTH     = 1 << MEM_AW;
  localparam logic [3:0] LAT_LOAD  = 4'(LATENCY - 1);
  localparam logic [4:0] LAST_BEAT = 5'(BLOCK_WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [31:0]       r_mem [DEPTH];

  logic [1:0]        r_state;
  logic [3:0]        r_lat;
  logic              r_write;
  logic [MEM_AW-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic [OFF-1:0]    r_off;
  logic [4:0]        r_beat;
  logic              r_resp_valid;
  logic [31:0]       r_resp_data;
  logic              r_resp_last;

  logic              w_idle;
  logic              w_accept;
  logic              w_lat_done;
  logic [MEM_AW-1:0] w_rd_addr;
  logic [31:0]       w_rd_data;
  logic [4:0]        w_next_beat;
  logic [OFF-1:0]    w_off_inc;
  logic              w_unused_addr;

  assign w_idle     = (r_state == S_IDLE);
  assign w_accept   = req_valid & w_idle;
  assign w_lat_done = (r_state == S_WAIT) && (r_lat == 4'd0);

  // r_off is the line offset of the next beat to issue. Keeping the line tag
  // from r_idx and letting r_off roll over in OFF bits makes the critical-word
  // wrap stay inside the line.
  assign w_rd_addr   = {r_idx[MEM_AW-1:OFF], r_off};
  assign w_rd_data   = r_mem[w_rd_addr];
  assign w_off_inc   = r_off + OFF'(1);
  assign w_next_beat = r_beat + 5'd1;

  // The upper address bits are intentionally dropped; this is what makes
  // addresses that differ only above MEM_AW-1 alias to the same word.
  assign w_unused_addr = ^req_addr[23:MEM_AW];

  assign req_ready  = w_idle;
  assign busy       = ~w_idle;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_last  = r_resp_last;

  // The store is written on the edge that enters ACK. A reset during WAIT
  // returns the FSM to IDLE before that edge, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (w_lat_done && r_write) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // Request FSM and registered response outputs. Every beat is registered
  // on the edge that starts its cycle. The latency counter is loaded with
  // LATENCY-1 on accept and checked for zero in WAIT, which puts the first
  // beat exactly LATENCY edges after the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_lat        <= 4'd0;
      r_write      <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= 32'd0;
      r_off        <= '0;
      r_beat       <= 5'd0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'd0;
      r_resp_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_WAIT;
            r_lat   <= LAT_LOAD;
            r_write <= req_write;
            r_idx   <= req_addr[MEM_AW-1:0];
            r_wdata <= req_wdata;
            r_off   <= req_addr[OFF-1:0];
          end
        end

        S_WAIT: begin
          if (r_lat == 4'd0) begin
            r_resp_valid <= 1'b1;
            if (r_write) begin
              r_state     <= S_ACK;
              r_resp_data <= r_wdata;
              r_resp_last <= 1'b1;
            end else begin
              r_state     <= S_BURST;
              r_resp_data <= w_rd_data;
              r_resp_last <= 1'b0;
              r_off       <= w_off_inc;
              r_beat      <= 5'd0;
            end
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end

        S_BURST: begin
          // The beat currently on the bus carries resp_last, so the burst
          // is complete and the outputs drop back to zero.
          if (r_resp_last) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
            r_resp_last  <= 1'b0;
          end else begin
            r_resp_data <= w_rd_data;
            r_resp_last <= (w_next_beat == LAST_BEAT);
            r_off       <= w_off_inc;
            r_beat      <= w_next_beat;
          end
        end

        S_ACK: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_data  <= 32'd0;
          r_resp_last  <= 1'b0;
        end

        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_data  <= 32'd0;
          r_resp_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder. It keeps a behavioural model made of
// three parts:
//   - a word array for the store;
//   - a timeline of expected response beats, keyed by cycle number;
//   - a busy window for the current request.
// A compare process checks every DUT output against that model on each
// falling edge. Directed scenarios add literal expectations. A randomized
// phase follows them.
//
// A cycle label c names the clock period that begins at rising edge number c.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_responder;

  localparam int LAT   = 3;
  localparam int BW    = 4;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [23:0] req_addr  = 24'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_last;
  logic        busy;

  mem_responder #(
    .MEM_AW(AW),
    .BLOCK_WORDS(BW),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .resp_last(resp_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  bit checkEnable = 1'b0;

  // Model state
  logic [31:0] modelMem [DEPTH];
  logic [33:0] expBeat [int];  // {valid, last, data}, keyed by cycle label
  int          busyFrom  = 0;
  int          busyTo    = 0;
  bit          pendValid = 1'b0;
  int          pendIdx   = 0;
  int          pendCycle = 0;
  logic [31:0] pendData  = 32'd0;

  function automatic bit modelReady(input int c);
    return !((c >= busyFrom) && (c < busyTo));
  endfunction

  function automatic void commitPending(input int c);
    if (pendValid && (pendCycle <= c)) begin
      modelMem[pendIdx] = pendData;
      pendValid = 1'b0;
    end
  endfunction

  // Request accepted at rising edge e: schedule its beats and busy window.
  function automatic void acceptModel(input int e, input bit w,
                                      input logic [23:0] a, input logic [31:0] d);
    int idx;
    int base;
    int word;
    idx = int'(a[AW-1:0]);
    commitPending(e);
    busyFrom = e;
    if (w) begin
      expBeat[e + LAT] = {1'b1, 1'b1, d};
      busyTo    = e + LAT + 1;
      pendValid = 1'b1;
      pendIdx   = idx;
      pendData  = d;
      pendCycle = e + LAT;
    end else begin
      base = idx - (idx % BW);
      for (int k = 0; k < BW; k++) begin
        word = base + (((idx % BW) + k) % BW);
        expBeat[e + LAT + k] = {1'b1, (k == BW - 1), modelMem[word]};
      end
      busyTo = e + LAT + BW;
    end
  endfunction

  // Reset asserted during cycle c. Beats from c onward are cancelled. A write
  // whose commit edge has not yet occurred is discarded.
  function automatic void modelReset(input int c);
    int keys[$];
    foreach (expBeat[k]) if (k >= c) keys.push_back(k);
    foreach (keys[i]) expBeat.delete(keys[i]);
    commitPending(c);
    pendValid = 1'b0;
    busyFrom  = 0;
    busyTo    = 0;
  endfunction

  function automatic void checkVal(input string name, input logic [31:0] act,
                                   input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h",
               name, cyc, act, exp);
    end
  endfunction

  function automatic void checkOutput();
    logic [33:0] e;
    bit          rdy;
    e   = expBeat.exists(cyc) ? expBeat[cyc] : 34'd0;
    rdy = modelReady(cyc);
    checkVal("resp_valid", 32'(resp_valid), 32'(e[33]));
    checkVal("resp_last",  32'(resp_last),  32'(e[32]));
    checkVal("resp_data",  resp_data,       e[31:0]);
    checkVal("req_ready",  32'(req_ready),  32'(rdy));
    checkVal("busy",       32'(busy),       32'(!rdy));
  endfunction

  // Per-cycle compare against the model, sampled away from the active edge
  always @(negedge clk) begin
    if (checkEnable) checkOutput();
  end

  // Present a request and hold it until the model says the responder is idle.
  // On return the bench sits at the falling edge of the accept cycle. The
  // inputs have already been scrambled there to show they no longer matter.
  task automatic applyStimulus(input bit w, input logic [23:0] a,
                               input logic [31:0] d, output int acc);
    int guard;
    guard = 0;
    acc   = -1;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!modelReady(cyc) && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!modelReady(cyc)) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept timeout at cycle %0d", cyc);
      req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    acceptModel(acc, w, a, d);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 24'($urandom);
    req_wdata = $urandom;
  endtask

  // Literal expectation for the beat in cycle label.
  task automatic expectBeat(input string name, input int label,
                            input logic [31:0] d, input bit last);
    int guard;
    guard = 0;
    while (cyc < label && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checkVal({name, " valid"}, 32'(resp_valid), 32'd1);
    checkVal({name, " data"},  resp_data,       d);
    checkVal({name, " last"},  32'(resp_last),  32'(last));
  endtask

  // Idle cycles. While busy, drive random requests that must be ignored.
  task automatic noise(input int n);
    repeat (n) begin
      @(negedge clk);
      if (!modelReady(cyc)) begin
        req_valid = 1'($urandom);
        req_write = 1'($urandom);
        req_addr  = 24'($urandom);
        req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
  endtask

  // Fill the store with mem[i] = i through write requests. Random upper
  // address bits exercise aliasing.
  task automatic initialize();
    int acc;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, {14'($urandom), 10'(i)}, 32'(i), acc);
    end
  endtask

  task automatic pulseReset();
    #2;
    rst_n = 1'b0;
    modelReset(cyc);
    #1;
    checkVal("abort resp_valid", 32'(resp_valid), 32'd0);
    checkVal("abort req_ready",  32'(req_ready),  32'd1);
    checkVal("abort busy",       32'(busy),       32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc;
    int acc2;
    bit w;
    logic [23:0] a;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkEnable = 1'b1;
    checkVal("reset resp_valid", 32'(resp_valid), 32'd0);
    checkVal("reset resp_data",  resp_data,       32'd0);
    checkVal("reset resp_last",  32'(resp_last),  32'd0);
    checkVal("reset req_ready",  32'(req_ready),  32'd1);
    checkVal("reset busy",       32'(busy),       32'd0);
    rst_n = 1'b1;

    $display("[TB] initializing store");
    initialize();

    $display("[TB] critical-word-first read");
    applyStimulus(1'b0, 24'h000005, $urandom, acc);
    expectBeat("t1 beat0", acc + 3, 32'd5, 1'b0);
    expectBeat("t1 beat1", acc + 4, 32'd6, 1'b0);
    expectBeat("t1 beat2", acc + 5, 32'd7, 1'b0);
    expectBeat("t1 beat3", acc + 6, 32'd4, 1'b1);

    $display("[TB] write ack then read-back");
    applyStimulus(1'b1, 24'h000009, 32'd46426, acc);
    expectBeat("t2 ack", acc + 3, 32'd46426, 1'b1);
    applyStimulus(1'b0, 24'h000008, $urandom, acc);
    expectBeat("t2 beat0", acc + 3, 32'd8,     1'b0);
    expectBeat("t2 beat1", acc + 4, 32'd46426, 1'b0);
    expectBeat("t2 beat2", acc + 5, 32'd10,    1'b0);
    expectBeat("t2 beat3", acc + 6, 32'd11,    1'b1);

    $display("[TB] aliasing and wrap");
    applyStimulus(1'b0, 24'hA7E5FB, $urandom, acc);
    expectBeat("t3 beat0", acc + 3, 32'd507, 1'b0);
    expectBeat("t3 beat1", acc + 4, 32'd504, 1'b0);
    expectBeat("t3 beat2", acc + 5, 32'd505, 1'b0);
    expectBeat("t3 beat3", acc + 6, 32'd506, 1'b1);

    $display("[TB] request held during burst");
    applyStimulus(1'b0, 24'h000010, $urandom, acc);
    applyStimulus(1'b0, 24'h000020, $urandom, acc2);
    checkVal("t4 accept edge", 32'(acc2), 32'(acc + 8));
    expectBeat("t4 second beat0", acc2 + 3, 32'd32, 1'b0);

    $display("[TB] reset during burst");
    noise(6);
    applyStimulus(1'b0, 24'h000040, $urandom, acc);
    expectBeat("t5 beat0", acc + 3, 32'd64, 1'b0);
    @(negedge clk);
    pulseReset();
    noise(8);

    $display("[TB] reset during write wait");
    applyStimulus(1'b1, 24'h000003, 32'd4235, acc);
    pulseReset();
    applyStimulus(1'b0, 24'h000000, $urandom, acc);
    expectBeat("t6 beat0", acc + 3, 32'd0, 1'b0);
    expectBeat("t6 beat1", acc + 4, 32'd1, 1'b0);
    expectBeat("t6 beat2", acc + 5, 32'd2, 1'b0);
    expectBeat("t6 beat3", acc + 6, 32'd3, 1'b1);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 200; t++) begin
      w = ($urandom_range(0, 9) < 3);
      a = 24'($urandom);
      if ($urandom_range(0, 1) == 1) a[9:0] = 10'($urandom_range(0, 31));
      applyStimulus(w, a, $urandom, acc);
      noise($urandom_range(0, 6));
    end
    noise(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
